// File: rtl/inta_sequencer.sv
// inta_sequencer: interrupt acknowledge control stage for an 8259-style
// controller. Picks the highest-priority serviceable request, raises INT,
// walks the two-pulse INTA handshake, freezes the acknowledged level for the
// ISR block, drives the vector byte and issues the AEOI clear strobe.
module inta_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
    parameter int         NUM_IRQ        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               INTA,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic [4:0]         V_A,
    input  logic               AEOI,
    output logic               INT,
    output logic               S_P,
    output logic [2:0]         highest_priority_int,
    output logic [7:0]         data_out,
    output logic               data_oe,
    output logic               aeoi_clear
);

    // The level field is three bits wide, so only eight request lines fit.
    if (NUM_IRQ != 8) begin : g_num_irq_check
        $error("inta_sequencer supports NUM_IRQ == 8 only");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT1,
        ST_ACK1,
        ST_WAIT2,
        ST_ACK2
    } state_e;

    state_e     state_q;
    logic       inta_q;
    logic       int_q;
    logic       sp_q;
    logic [2:0] level_q;
    logic       spur_q;     // acknowledged level was the spurious default
    logic [7:0] dout_q;
    logic       doe_q;
    logic       aeoi_q;

    logic [NUM_IRQ-1:0] pending;
    logic               res_valid;
    logic               res_blocked;
    logic [2:0]         res_cand;
    logic               fall;
    logic               rise;

    assign pending = irr & ~imr;
    assign fall    = inta_q & ~INTA;
    assign rise    = ~inta_q & INTA;

    // Fixed-priority resolver: scan from level 0 upward; an in-service bit
    // blocks its own level and everything of lower priority.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        res_valid   = 1'b0;
        res_blocked = 1'b0;
        res_cand    = 3'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!res_blocked && !res_valid) begin
                if (isr[i]) begin
                    res_blocked = 1'b1;
                end else if (pending[i]) begin
                    res_valid = 1'b1;
                    res_cand  = i[2:0];
                end
            end
        end
    end

    // Handshake sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q <= ST_IDLE;
            inta_q  <= 1'b1;
            int_q   <= 1'b0;
            sp_q    <= 1'b0;
            level_q <= 3'd0;
            spur_q  <= 1'b0;
            dout_q  <= 8'h00;
            doe_q   <= 1'b0;
            aeoi_q  <= 1'b0;
        end else begin
            inta_q <= INTA;
            sp_q   <= 1'b0;
            aeoi_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (res_valid) begin
                        int_q   <= 1'b1;
                        state_q <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (fall) begin
                        // Level is frozen here and held until the next first fall.
                        level_q <= res_valid ? res_cand : SPURIOUS_LEVEL;
                        spur_q  <= ~res_valid;
                        sp_q    <= res_valid;
                        int_q   <= 1'b0;
                        state_q <= ST_ACK1;
                    end else if (!res_valid) begin
                        int_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACK1: begin
                    if (rise) begin
                        state_q <= ST_WAIT2;
                    end
                end
                ST_WAIT2: begin
                    if (fall) begin
                        dout_q  <= {V_A, level_q};
                        doe_q   <= 1'b1;
                        state_q <= ST_ACK2;
                    end
                end
                ST_ACK2: begin
                    if (rise) begin
                        doe_q   <= 1'b0;
                        aeoi_q  <= AEOI & ~spur_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign INT                  = int_q;
    assign S_P                  = sp_q;
    assign highest_priority_int = level_q;
    assign data_out             = dout_q;
    assign data_oe              = doe_q;
    assign aeoi_clear           = aeoi_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Testbench for inta_sequencer: reset checks, a table of resolver/handshake
// vectors, hand-written corner sequences and a randomized run, all compared
// every cycle against a transaction-level reference model.
module tb_inta_sequencer;

    logic       clk;
    logic       reset;
    logic       INTA;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [7:0] isr;
    logic [4:0] V_A;
    logic       AEOI;
    logic       INT;
    logic       S_P;
    logic [2:0] highest_priority_int;
    logic [7:0] data_out;
    logic       data_oe;
    logic       aeoi_clear;

    int n_checks = 0;
    int n_fail   = 0;

    inta_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .INTA                 (INTA),
        .irr                  (irr),
        .imr                  (imr),
        .isr                  (isr),
        .V_A                  (V_A),
        .AEOI                 (AEOI),
        .INT                  (INT),
        .S_P                  (S_P),
        .highest_priority_int (highest_priority_int),
        .data_out             (data_out),
        .data_oe              (data_oe),
        .aeoi_clear           (aeoi_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Priority: requests below the lowest in-service bit are eligible; the
    // winner is the lowest set eligible bit.
    function automatic void resolve(input logic [7:0] r, input logic [7:0] m,
                                    input logic [7:0] s, output bit v, output logic [2:0] c);
        logic [7:0] low_isr;
        logic [7:0] allowed;
        logic [7:0] elig;
        low_isr = s & (~s + 8'd1);
        allowed = (s == 8'h00) ? 8'hFF : (low_isr - 8'd1);
        elig    = r & ~m & allowed;
        v       = (elig != 8'h00);
        c       = v ? 3'($clog2(elig & (~elig + 8'd1))) : 3'd0;
    endfunction

    // m_stage counts handshake progress: 0 no request, 1 INT raised,
    // 2 first pulse in progress, 3 between pulses, 4 second pulse in progress.
    bit         m_inta_q;
    int         m_stage;
    bit         m_int, m_sp, m_spur, m_doe, m_aeoi;
    logic [2:0] m_level;
    logic [7:0] m_vec;

    task automatic model_reset();
        m_inta_q = 1'b1;
        m_stage  = 0;
        m_int    = 1'b0;
        m_sp     = 1'b0;
        m_spur   = 1'b0;
        m_doe    = 1'b0;
        m_aeoi   = 1'b0;
        m_level  = 3'd0;
        m_vec    = 8'h00;
    endtask

    task automatic model_update();
        bit         v;
        logic [2:0] c;
        bit         fall_e;
        bit         rise_e;
        resolve(irr, imr, isr, v, c);
        fall_e = m_inta_q && !INTA;
        rise_e = !m_inta_q && INTA;
        m_sp   = 1'b0;
        m_aeoi = 1'b0;
        case (m_stage)
            0: if (v) begin m_int = 1'b1; m_stage = 1; end
            1: begin
                if (fall_e) begin
                    m_level = v ? c : 3'd7;
                    m_spur  = !v;
                    m_sp    = v;
                    m_int   = 1'b0;
                    m_stage = 2;
                end else if (!v) begin
                    m_int   = 1'b0;
                    m_stage = 0;
                end
            end
            2: if (rise_e) m_stage = 3;
            3: if (fall_e) begin m_vec = {V_A, m_level}; m_doe = 1'b1; m_stage = 4; end
            4: if (rise_e) begin m_doe = 1'b0; m_aeoi = AEOI && !m_spur; m_stage = 0; end
            default: m_stage = 0;
        endcase
        m_inta_q = INTA;
    endtask

    // One clock: advance the model on current inputs, then compare just after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("m_int", 32'(INT), 32'(m_int));
        check("m_sp", 32'(S_P), 32'(m_sp));
        check("m_level", 32'(highest_priority_int), 32'(m_level));
        check("m_oe", 32'(data_oe), 32'(m_doe));
        check("m_aeoi", 32'(aeoi_clear), 32'(m_aeoi));
        if (m_doe) check("m_vec", 32'(data_out), 32'(m_vec));
    endtask

    // Full two-pulse handshake starting from WAIT1 with INTA high.
    task automatic do_ack(input logic [2:0] lvl, input logic sp_exp, input logic aeoi_exp,
                          input logic [4:0] va2, input bit withdraw);
        if (withdraw) irr = 8'h00;
        INTA = 1'b0; step();
        check("sp_pulse", 32'(S_P), 32'(sp_exp));
        check("level", 32'(highest_priority_int), 32'(lvl));
        check("int_drop", 32'(INT), 0);
        irr = 8'h00;
        step();
        check("sp_once", 32'(S_P), 0);
        INTA = 1'b1; step();
        check("oe_gap", 32'(data_oe), 0);
        V_A = va2;
        INTA = 1'b0; step();
        check("oe_high", 32'(data_oe), 1);
        check("vector", 32'(data_out), 32'({va2, lvl}));
        step();
        check("oe_hold", 32'(data_oe), 1);
        INTA = 1'b1; step();
        check("oe_drop", 32'(data_oe), 0);
        check("aeoi_pulse", 32'(aeoi_clear), 32'(aeoi_exp));
        step();
        check("aeoi_once", 32'(aeoi_clear), 0);
        check("int_after", 32'(INT), 0);
    endtask

    typedef struct {
        logic [7:0] irr;
        logic [7:0] imr;
        logic [7:0] isr;
        logic       aeoi;
        logic       exp_valid;
        logic [2:0] exp_level;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{8'h20, 8'h00, 8'h00, 1'b0, 1'b1, 3'd5};
        tbl[1] = '{8'h24, 8'h00, 8'h02, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 3'd2};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[4] = '{8'h81, 8'h01, 8'h00, 1'b0, 1'b1, 3'd7};
        tbl[5] = '{8'h0C, 8'h04, 8'h08, 1'b0, 1'b0, 3'd0};
        tbl[6] = '{8'h0C, 8'h04, 8'h10, 1'b0, 1'b1, 3'd3};
        tbl[7] = '{8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0};
        tbl[8] = '{8'h06, 8'h00, 8'h80, 1'b0, 1'b1, 3'd1};
        tbl[9] = '{8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 3'd7};

        reset = 1'b1; INTA = 1'b1; irr = 8'h00; imr = 8'h00; isr = 8'h00;
        V_A = 5'h08; AEOI = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_int", 32'(INT), 0);
        check("rst_sp", 32'(S_P), 0);
        check("rst_level", 32'(highest_priority_int), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_oe", 32'(data_oe), 0);
        check("rst_aeoi", 32'(aeoi_clear), 0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven resolver and handshake vectors.
        for (int k = 0; k < 10; k++) begin
            irr = tbl[k].irr; imr = tbl[k].imr; isr = tbl[k].isr; AEOI = tbl[k].aeoi;
            V_A = 5'h08; INTA = 1'b1;
            step();
            check("tbl_int", 32'(INT), 32'(tbl[k].exp_valid));
            step();
            check("tbl_int_hold", 32'(INT), 32'(tbl[k].exp_valid));
            if (tbl[k].exp_valid) begin
                do_ack(tbl[k].exp_level, 1'b1, tbl[k].aeoi, 5'h08, 1'b0);
            end else begin
                INTA = 1'b0; step();
                check("ign_sp", 32'(S_P), 0);
                INTA = 1'b1; step();
                INTA = 1'b0; step();
                check("ign_oe", 32'(data_oe), 0);
                INTA = 1'b1; step();
                check("ign_int", 32'(INT), 0);
            end
            irr = 8'h00; imr = 8'h00; isr = 8'h00; AEOI = 1'b0;
            step();
            step();
        end

        // Request withdrawn before the first INTA pulse.
        irr = 8'h08; step();
        check("wd_int_up", 32'(INT), 1);
        irr = 8'h00; step();
        check("wd_int_down", 32'(INT), 0);
        step();
        check("wd_idle", 32'(INT), 0);

        // Request withdrawn in the same cycle as the first fall: spurious level,
        // no S_P, no AEOI clear, and V_A changed between pulses.
        AEOI = 1'b1; irr = 8'h08; step();
        check("sp_int_up", 32'(INT), 1);
        do_ack(3'd7, 1'b0, 1'b0, 5'h13, 1'b1);
        AEOI = 1'b0; V_A = 5'h08;
        step();

        // Reset while in ACK2 with the vector on the bus.
        irr = 8'h10; step();
        INTA = 1'b0; step();
        INTA = 1'b1; step();
        INTA = 1'b0; step();
        check("pre_rst_oe", 32'(data_oe), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_oe", 32'(data_oe), 0);
        check("arst_int", 32'(INT), 0);
        check("arst_sp", 32'(S_P), 0);
        check("arst_aeoi", 32'(aeoi_clear), 0);
        model_reset();
        irr = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_sp", 32'(S_P), 0);
        INTA = 1'b1; step();
        INTA = 1'b0; step();
        check("post_rst_oe", 32'(data_oe), 0);
        INTA = 1'b1; step();
        check("post_rst_int", 32'(INT), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) irr = 8'($urandom);
            if ($urandom_range(0, 15) == 0) imr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 15) == 0)
                isr = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) INTA = ~INTA;
            if ($urandom_range(0, 31) == 0) V_A = 5'($urandom);
            if ($urandom_range(0, 15) == 0) AEOI = ~AEOI;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
